// File: rtl/axi_lite_write_arbiter_if.sv
// axi_lite_write_arbiter_if
//   Bundles the requester side and the write-master side of the arbiter.
//   Requester side : req_valid/req_addr/req_data/req_strb in, req_done/req_err out.
//                    Payloads are packed; requester i sits at [i*W +: W].
//   Master side    : write_en/write_addr_in/write_data_in/strobe_in out, write_done in.
//   Status         : busy, grant_id.
//   modport master : the arbiter's view.
//   modport slave  : the view of the requesters plus the write master.
`ifndef WIDTH_ADDR
`define WIDTH_ADDR 32
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 32
`endif

interface axi_lite_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = `WIDTH_ADDR,
    parameter int DATA_W = `WIDTH_DATA
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ*4-1:0]      req_strb;
    logic [N_REQ-1:0]        req_done;
    logic [N_REQ-1:0]        req_err;
    logic                    write_en;
    logic [ADDR_W-1:0]       write_addr_in;
    logic [DATA_W-1:0]       write_data_in;
    logic [3:0]              strobe_in;
    logic                    write_done;
    logic                    busy;
    logic [IDW-1:0]          grant_id;

    modport master (
        input  req_valid, req_addr, req_data, req_strb, write_done,
        output req_done, req_err, write_en, write_addr_in, write_data_in,
               strobe_in, busy, grant_id
    );

    modport slave (
        output req_valid, req_addr, req_data, req_strb, write_done,
        input  req_done, req_err, write_en, write_addr_in, write_data_in,
               strobe_in, busy, grant_id
    );
endinterface

// File: rtl/axi_lite_write_arbiter.sv
// axi_lite_write_arbiter
//   Shares one AXI4-Lite write-master command port among N_REQ requesters.
//   Round-robin grant, one write in flight, per-requester done/err pulses,
//   watchdog that abandons a write after TIMEOUT cycles (0 disables it).
// Ports
//   clk   : clock, everything on posedge
//   reset : asynchronous, active-high
//   bus   : axi_lite_write_arbiter_if.master (requester + write-master signals)
`ifndef WIDTH_ADDR
`define WIDTH_ADDR 32
`endif
`ifndef WIDTH_DATA
`define WIDTH_DATA 32
`endif

module axi_lite_write_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = `WIDTH_ADDR,
    parameter int DATA_W  = `WIDTH_DATA,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    axi_lite_write_arbiter_if.master bus
);
    localparam int IDW = $clog2(N_REQ);
    // Counter sized to hold TIMEOUT; kept at least 1 bit when disabled.
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter starts at 0 on the first WRITE cycle, so TIMEOUT-1 marks the
    // TIMEOUT-th edge spent in WRITE.
    localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_found;
    logic [N_REQ-1:0]  gnt_oh;
    logic [CW-1:0]     tmo_cnt;
    logic              tmo_hit;
    logic              grant_fire, done_fire, err_fire;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        strb_q;
    logic [N_REQ-1:0]  done_q, err_q;

    // Round-robin scan starting just after the last grant.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!gnt_found && bus.req_valid[IDW'((int'(ptr) + k) % N_REQ)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign gnt_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        done_fire  = 1'b0;
        err_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    grant_fire = 1'b1;
                    state_nxt  = WRITE;
                end
            end
            WRITE: begin
                // write_done takes priority over a coincident timeout.
                if (bus.write_done) begin
                    done_fire = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    err_fire  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= IDW'(N_REQ - 1);
            grant_id <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            tmo_cnt  <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (grant_fire) begin
                ptr      <= gnt_idx;
                grant_id <= gnt_idx;
                addr_q   <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
                data_q   <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
                strb_q   <= bus.req_strb[gnt_idx*4 +: 4];
                tmo_cnt  <= '0;
            end else if (state == WRITE && tmo_cnt != CNT_MAX) begin
                // Saturates rather than wrapping when the watchdog is off.
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (done_fire) done_q <= gnt_oh;
            if (err_fire)  err_q  <= gnt_oh;
        end
    end

    // write_en/busy decode straight from state so reset drops them at once.
    assign bus.write_en      = (state == WRITE);
    assign bus.busy          = (state != IDLE);
    assign bus.write_addr_in = addr_q;
    assign bus.write_data_in = data_q;
    assign bus.strobe_in     = strb_q;
    assign bus.grant_id      = grant_id;
    assign bus.req_done      = done_q;
    assign bus.req_err       = err_q;
endmodule
